// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: keeps one bus request in flight and buffers fetched words in an output register plus a one-entry skid buffer.
// Defining IFETCH_MISALIGN_CHECK_EN adds misaligned-PC trapping (STOP state, f_exc beat).
module ifetch_ctrl #(
   parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   input  logic        stall,
   input  logic        redir_valid,
   input  logic [63:0] redir_pc,
   output logic        f_valid,
   output logic [63:0] f_pc,
   output logic [31:0] f_instr,
   output logic        f_exc
);

`ifdef IFETCH_MISALIGN_CHECK_EN
   typedef enum logic [1:0] {FETCH, DISCARD, HOLD, STOP} stateT;
`else
   typedef enum logic [1:0] {FETCH, DISCARD, HOLD} stateT;
`endif

   stateT       state, stateNext;
   logic [63:0] pc, pcNext;
   logic        skValid;
   logic [63:0] skPc;
   logic [31:0] skInstr;

   logic        accept, slotFree, misaligned, reqPending;
   logic        loadOut, skidToOut, clrOut, loadSkid, clrSkid;
   logic [63:0] outPc;
   logic [31:0] outInstr;

   assign accept   = f_valid & ~stall;
   assign slotFree = ~f_valid | accept;

`ifdef IFETCH_MISALIGN_CHECK_EN
   logic outExc;
   assign misaligned = (pc[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
   assign f_exc      = 1'b0;
`endif

   // Request is held combinationally low while reset is asserted.
   assign ireq_valid = reset & (((state == FETCH) & ~misaligned) | (state == DISCARD));
   assign reqPending = ireq_valid & ~iresp_data_ok;

   always_comb begin
      stateNext = state;
      pcNext    = pc;
      loadOut   = 1'b0;
      skidToOut = 1'b0;
      clrOut    = 1'b0;
      loadSkid  = 1'b0;
      clrSkid   = 1'b0;
      outPc     = ireq_addr;
      outInstr  = iresp_data;
`ifdef IFETCH_MISALIGN_CHECK_EN
      outExc    = 1'b0;
`endif
      if (redir_valid) begin
         pcNext  = redir_pc;
         clrOut  = 1'b1;
         clrSkid = 1'b1;
         case (state)
            FETCH:   stateNext = reqPending ? DISCARD : FETCH;
            DISCARD: stateNext = iresp_data_ok ? FETCH : DISCARD;
            default: stateNext = FETCH;
         endcase
      end else begin
         clrOut = accept;
         case (state)
            FETCH: begin
`ifdef IFETCH_MISALIGN_CHECK_EN
               if (misaligned) begin
                  if (slotFree) begin
                     loadOut   = 1'b1;
                     outPc     = pc;
                     outInstr  = 32'h0;
                     outExc    = 1'b1;
                     stateNext = STOP;
                  end
               end else
`endif
               if (iresp_data_ok) begin
                  pcNext = pc + 64'd4;
                  if (slotFree) begin
                     loadOut = 1'b1;
                  end else begin
                     loadSkid  = 1'b1;
                     stateNext = HOLD;
                  end
               end
            end
            DISCARD: if (iresp_data_ok) stateNext = FETCH;
            HOLD: begin
               if (accept && skValid) begin
                  skidToOut = 1'b1;
                  clrSkid   = 1'b1;
                  stateNext = FETCH;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= FETCH;
         pc        <= RESET_PC;
         ireq_addr <= RESET_PC;
         f_valid   <= 1'b0;
         f_pc      <= 64'h0;
         f_instr   <= 32'h0;
`ifdef IFETCH_MISALIGN_CHECK_EN
         f_exc     <= 1'b0;
`endif
         skValid   <= 1'b0;
         skPc      <= 64'h0;
         skInstr   <= 32'h0;
      end else begin
         state <= stateNext;
         pc    <= pcNext;
         // Address is frozen while a request waits for its response.
         if (!reqPending) ireq_addr <= pcNext;

         if (loadOut) begin
            f_valid <= 1'b1;
            f_pc    <= outPc;
            f_instr <= outInstr;
`ifdef IFETCH_MISALIGN_CHECK_EN
            f_exc   <= outExc;
`endif
         end else if (skidToOut) begin
            f_valid <= 1'b1;
            f_pc    <= skPc;
            f_instr <= skInstr;
`ifdef IFETCH_MISALIGN_CHECK_EN
            f_exc   <= 1'b0;
`endif
         end else if (clrOut) begin
            f_valid <= 1'b0;
         end

         if (loadSkid) begin
            skValid <= 1'b1;
            skPc    <= ireq_addr;
            skInstr <= iresp_data;
         end else if (clrSkid) begin
            skValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: per-cycle vector table plus hand sequences for async reset and misaligned PC.
module tb_ifetch_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_data_ok = 1'b0;
   logic [31:0] iresp_data = 32'h0;
   logic        stall = 1'b0;
   logic        redir_valid = 1'b0;
   logic [63:0] redir_pc = 64'h0;
   logic        f_valid;
   logic [63:0] f_pc;
   logic [31:0] f_instr;
   logic        f_exc;

   int passed = 0;
   int total  = 0;

   ifetch_ctrl #(.RESET_PC(64'h8000_0000)) dut (
      .clk(clk), .reset(reset),
      .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
      .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
      .stall(stall), .redir_valid(redir_valid), .redir_pc(redir_pc),
      .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr), .f_exc(f_exc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        ok;
      logic [31:0] data;
      logic        stl;
      logic        rv;
      logic [63:0] rpc;
      logic        eIv;
      logic [63:0] eAddr;
      logic        eFv;
      logic [63:0] ePc;
      logic [31:0] eInstr;
   } vecT;

   vecT vecs[29];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Drive one cycle of inputs at the falling edge; outputs are sampled 1ns later.
   task automatic step(input logic rst, input logic ok, input logic [31:0] d, input logic s,
                       input logic rv, input logic [63:0] rpc);
      @(negedge clk);
      reset = rst; iresp_data_ok = ok; iresp_data = d; stall = s;
      redir_valid = rv; redir_pc = rpc;
      #1;
   endtask

   localparam logic [63:0] A = 64'h8000_0000;

   initial begin
      //          ok  data          stl rv  rpc              eIv eAddr          eFv ePc           eInstr
      vecs[0]  = '{1, 32'hC0DE0000, 0, 0, 64'h0,            1, A,             0, 64'h0,        32'h0};
      vecs[1]  = '{1, 32'hC0DE0004, 0, 0, 64'h0,            1, A+4,           1, A,            32'hC0DE0000};
      vecs[2]  = '{1, 32'hC0DE0008, 0, 0, 64'h0,            1, A+8,           1, A+4,          32'hC0DE0004};
      vecs[3]  = '{1, 32'hC0DE000C, 0, 0, 64'h0,            1, A+12,          1, A+8,          32'hC0DE0008};
      vecs[4]  = '{1, 32'hC0DE0010, 0, 0, 64'h0,            1, A+16,          1, A+12,         32'hC0DE000C};
      vecs[5]  = '{1, 32'hC0DE0014, 1, 0, 64'h0,            1, A+20,          1, A+16,         32'hC0DE0010};
      vecs[6]  = '{0, 32'h0,        1, 0, 64'h0,            0, A+24,          1, A+16,         32'hC0DE0010};
      vecs[7]  = '{0, 32'h0,        1, 0, 64'h0,            0, A+24,          1, A+16,         32'hC0DE0010};
      vecs[8]  = '{0, 32'h0,        0, 0, 64'h0,            0, A+24,          1, A+16,         32'hC0DE0010};
      vecs[9]  = '{0, 32'h0,        0, 0, 64'h0,            1, A+24,          1, A+20,         32'hC0DE0014};
      vecs[10] = '{1, 32'hC0DE0018, 0, 0, 64'h0,            1, A+24,          0, 64'h0,        32'h0};
      vecs[11] = '{1, 32'hC0DE001C, 0, 0, 64'h0,            1, A+28,          1, A+24,         32'hC0DE0018};
      vecs[12] = '{0, 32'h0,        0, 1, 64'h8000_1000,    1, A+32,          1, A+28,         32'hC0DE001C};
      vecs[13] = '{0, 32'h0,        0, 0, 64'h0,            1, A+32,          0, 64'h0,        32'h0};
      vecs[14] = '{0, 32'h0,        0, 0, 64'h0,            1, A+32,          0, 64'h0,        32'h0};
      vecs[15] = '{1, 32'hC0DE0020, 0, 0, 64'h0,            1, A+32,          0, 64'h0,        32'h0};
      vecs[16] = '{1, 32'hC0DE1000, 1, 0, 64'h0,            1, 64'h8000_1000, 0, 64'h0,        32'h0};
      vecs[17] = '{1, 32'hC0DE1004, 1, 1, 64'h8000_2000,    1, 64'h8000_1004, 1, 64'h8000_1000, 32'hC0DE1000};
      vecs[18] = '{1, 32'hC0DE2000, 1, 0, 64'h0,            1, 64'h8000_2000, 0, 64'h0,        32'h0};
      vecs[19] = '{1, 32'hC0DE2004, 1, 0, 64'h0,            1, 64'h8000_2004, 1, 64'h8000_2000, 32'hC0DE2000};
      vecs[20] = '{0, 32'h0,        1, 1, 64'h8000_3000,    0, 64'h8000_2008, 1, 64'h8000_2000, 32'hC0DE2000};
      vecs[21] = '{0, 32'h0,        0, 1, 64'h8000_5000,    1, 64'h8000_3000, 0, 64'h0,        32'h0};
      vecs[22] = '{0, 32'h0,        0, 1, 64'h8000_6000,    1, 64'h8000_3000, 0, 64'h0,        32'h0};
      vecs[23] = '{1, 32'hDEADBEEF, 0, 0, 64'h0,            1, 64'h8000_3000, 0, 64'h0,        32'h0};
      vecs[24] = '{1, 32'hC0DE6000, 0, 0, 64'h0,            1, 64'h8000_6000, 0, 64'h0,        32'h0};
      vecs[25] = '{1, 32'hC0DE6004, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h8000_6004, 1, 64'h8000_6000, 32'hC0DE6000};
      vecs[26] = '{1, 32'hC0DEFFFC, 0, 0, 64'h0,            1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 32'h0};
      vecs[27] = '{0, 32'h0,        0, 0, 64'h0,            1, 64'h0,         1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hC0DEFFFC};
      vecs[28] = '{0, 32'h0,        0, 0, 64'h0,            1, 64'h0,         0, 64'h0,        32'h0};

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ireq_valid", {63'h0, ireq_valid}, 64'h0);
      chk("rst_ireq_addr", ireq_addr, A);
      chk("rst_f_valid", {63'h0, f_valid}, 64'h0);
      chk("rst_f_pc", f_pc, 64'h0);
      chk("rst_f_instr", {32'h0, f_instr}, 64'h0);
      chk("rst_f_exc", {63'h0, f_exc}, 64'h0);

      for (int i = 0; i < 29; i++) begin
         step(1'b1, vecs[i].ok, vecs[i].data, vecs[i].stl, vecs[i].rv, vecs[i].rpc);
         chk($sformatf("v%0d_ireq_valid", i), {63'h0, ireq_valid}, {63'h0, vecs[i].eIv});
         chk($sformatf("v%0d_ireq_addr", i), ireq_addr, vecs[i].eAddr);
         chk($sformatf("v%0d_f_valid", i), {63'h0, f_valid}, {63'h0, vecs[i].eFv});
         chk($sformatf("v%0d_f_exc", i), {63'h0, f_exc}, 64'h0);
         if (vecs[i].eFv) begin
            chk($sformatf("v%0d_f_pc", i), f_pc, vecs[i].ePc);
            chk($sformatf("v%0d_f_instr", i), {32'h0, f_instr}, {32'h0, vecs[i].eInstr});
         end
      end

`ifdef IFETCH_MISALIGN_CHECK_EN
      // Misaligned redirect: exception beat, no bus traffic until redirected away.
      step(1, 1, 32'h1111_1111, 0, 1, 64'h8000_0002);
      step(1, 0, 32'h0, 1, 0, 64'h0);
      chk("mis_no_req0", {63'h0, ireq_valid}, 64'h0);
      chk("mis_fv0", {63'h0, f_valid}, 64'h0);
      step(1, 0, 32'h0, 1, 0, 64'h0);
      chk("mis_no_req1", {63'h0, ireq_valid}, 64'h0);
      chk("mis_fv1", {63'h0, f_valid}, 64'h1);
      chk("mis_exc", {63'h0, f_exc}, 64'h1);
      chk("mis_pc", f_pc, 64'h8000_0002);
      chk("mis_instr", {32'h0, f_instr}, 64'h0);
      step(1, 0, 32'h0, 0, 0, 64'h0);
      chk("mis_fv2", {63'h0, f_valid}, 64'h1);
      step(1, 0, 32'h0, 0, 0, 64'h0);
      chk("mis_stop_no_req", {63'h0, ireq_valid}, 64'h0);
      chk("mis_fv3", {63'h0, f_valid}, 64'h0);
      step(1, 0, 32'h0, 0, 1, 64'h8000_0100);
      chk("mis_stop_no_req2", {63'h0, ireq_valid}, 64'h0);
      step(1, 1, 32'hC0DE0100, 0, 0, 64'h0);
      chk("mis_resume_valid", {63'h0, ireq_valid}, 64'h1);
      chk("mis_resume_addr", ireq_addr, 64'h8000_0100);
      step(1, 0, 32'h0, 0, 0, 64'h0);
      chk("mis_resume_fpc", f_pc, 64'h8000_0100);
      chk("mis_resume_exc", {63'h0, f_exc}, 64'h0);
`endif

      // Asynchronous reset between clock edges abandons the outstanding request.
      step(1, 0, 32'h0, 0, 0, 64'h0);
      #2 reset = 1'b0;
      #1;
      chk("async_ireq_valid", {63'h0, ireq_valid}, 64'h0);
      chk("async_ireq_addr", ireq_addr, A);
      chk("async_f_valid", {63'h0, f_valid}, 64'h0);
      chk("async_f_pc", f_pc, 64'h0);
      chk("async_f_instr", {32'h0, f_instr}, 64'h0);
      step(0, 1, 32'h2222_2222, 0, 0, 64'h0);
      step(1, 1, 32'hC0DE0000, 0, 0, 64'h0);
      chk("rel_ireq_valid", {63'h0, ireq_valid}, 64'h1);
      chk("rel_ireq_addr", ireq_addr, A);
      chk("rel_f_valid", {63'h0, f_valid}, 64'h0);
      step(1, 0, 32'h0, 0, 0, 64'h0);
      chk("rel_f_pc", f_pc, A);
      chk("rel_f_instr", {32'h0, f_instr}, 64'h0000_0000_C0DE_0000);
      chk("rel_next_addr", ireq_addr, A + 4);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
